// File: rtl/ldl_event_pend_pri_v1.sv
// Sticky event-pending collector that issues pending events one at a time,
// lowest index first, as binary indices on a valid/ready port.
module ldl_event_pend_pri_v1 #(
  parameter int BIN_WIDTH = 4,
  parameter int HOT_WIDTH = 1 << BIN_WIDTH  // must not exceed 2**BIN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [HOT_WIDTH-1:0] set_i,
  input  logic [HOT_WIDTH-1:0] mask_i,
  input  logic                 flush_i,
  output logic [HOT_WIDTH-1:0] pend_o,
  output logic                 any_o,
  output logic [HOT_WIDTH-1:0] drop_o,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIN_WIDTH-1:0] out_idx
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t               state;
  logic [HOT_WIDTH-1:0] pend;
  logic [HOT_WIDTH-1:0] elig;
  logic [HOT_WIDTH-1:0] rec;
  logic [HOT_WIDTH-1:0] clr;
  logic [HOT_WIDTH-1:0] pend_nxt;
  logic [HOT_WIDTH-1:0] drop_nxt;
  logic [BIN_WIDTH-1:0] sel;
  logic                 load;

  assign elig = pend & mask_i;
  assign rec  = set_i & mask_i;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel = '0;
    // Scanning high to low lets the lowest eligible index win.
    for (int j = HOT_WIDTH - 1; j >= 0; j--) begin
      if (elig[j]) sel = BIN_WIDTH'(j);
    end
  end

  // A load happens whenever something is eligible and the output slot is free
  // or being freed by a handshake this cycle.
  assign load = (elig != '0) && ((state == IDLE) || out_ready);

  always_comb begin
    clr = '0;
    if (load) clr[sel] = 1'b1;
  end

  // A fresh record on the bit being issued re-pends it, so set wins over clr.
  assign pend_nxt = (pend & ~clr) | rec;
  assign drop_nxt = rec & pend & ~clr;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend      <= '0;
      drop_o    <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else if (flush_i) begin
      state     <= IDLE;
      pend      <= '0;
      drop_o    <= '0;
      out_valid <= 1'b0;
    end else begin
      pend   <= pend_nxt;
      drop_o <= drop_nxt;
      case (state)
        IDLE: begin
          if (load) begin
            out_idx   <= sel;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (load) begin
              out_idx <= sel;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pend_o = pend;
  assign any_o  = |pend;

endmodule

// File: tb/tb_ldl_event_pend_pri_v1.sv
// Directed self-checking bench for ldl_event_pend_pri_v1: latency, priority,
// hold stability, drops, masking, flush and asynchronous reset.
module tb_ldl_event_pend_pri_v1;

  localparam int BW = 4;
  localparam int HW = 1 << BW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [HW-1:0] set_i;
  logic [HW-1:0] mask_i;
  logic          flush_i;
  logic [HW-1:0] pend_o;
  logic          any_o;
  logic [HW-1:0] drop_o;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_idx;

  int passed = 0;
  int total  = 0;

  ldl_event_pend_pri_v1 #(.BIN_WIDTH(BW), .HOT_WIDTH(HW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_i     (set_i),
    .mask_i    (mask_i),
    .flush_i   (flush_i),
    .pend_o    (pend_o),
    .any_o     (any_o),
    .drop_o    (drop_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are observed and inputs changed 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; set_i = '0; mask_i = '1; flush_i = 1'b0; out_ready = 1'b1;
    step(); step();
    total++; if (pend_o !== 16'h0000) $display("FAIL reset_pend got=%h exp=0000", pend_o); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else passed++;
    total++; if (out_idx !== 4'd0) $display("FAIL reset_idx got=%0d exp=0", out_idx); else passed++;
    total++; if (drop_o !== 16'h0000 || any_o !== 1'b0) $display("FAIL reset_drop_any drop=%h any=%b exp=0000/0", drop_o, any_o); else passed++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_latency();
    set_i = 16'h0001; out_ready = 1'b1;
    step();
    set_i = '0;
    total++; if (pend_o !== 16'h0001 || out_valid !== 1'b0) $display("FAIL lat_n1 pend=%h valid=%b exp=0001/0", pend_o, out_valid); else passed++;
    total++; if (any_o !== 1'b1) $display("FAIL lat_any got=%b exp=1", any_o); else passed++;
    step();
    total++; if (out_valid !== 1'b1 || out_idx !== 4'd0 || pend_o !== 16'h0000) $display("FAIL lat_n2 valid=%b idx=%0d pend=%h exp=1/0/0000", out_valid, out_idx, pend_o); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL lat_n3 valid=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_seq [3];
    exp_seq[0] = 4'd5; exp_seq[1] = 4'd10; exp_seq[2] = 4'd15;
    out_ready = 1'b0; set_i = 16'h8421;
    step();
    set_i = '0;
    total++; if (pend_o !== 16'h8421) $display("FAIL b2b_pend got=%h exp=8421", pend_o); else passed++;
    for (int c = 0; c < 5; c++) begin
      step();
      total++; if (out_valid !== 1'b1 || out_idx !== 4'd0) $display("FAIL b2b_hold%0d valid=%b idx=%0d exp=1/0", c, out_valid, out_idx); else passed++;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (out_valid !== 1'b1 || out_idx !== exp_seq[k]) $display("FAIL b2b_issue%0d valid=%b idx=%0d exp=1/%0d", k, out_valid, out_idx, exp_seq[k]); else passed++;
    end
    step();
    total++; if (out_valid !== 1'b0 || out_idx !== 4'd15 || pend_o !== 16'h0000) $display("FAIL b2b_end valid=%b idx=%0d pend=%h exp=0/15/0000", out_valid, out_idx, pend_o); else passed++;
  endtask

  // Hold index 0 in the output slot so a second event can sit in pend.
  task automatic occupy_slot();
    out_ready = 1'b0; set_i = 16'h0001;
    step();
    set_i = '0;
    step();
  endtask

  task automatic test_drop();
    occupy_slot();
    set_i = 16'h0008;
    step();
    total++; if (pend_o !== 16'h0008 || drop_o !== 16'h0000) $display("FAIL drop_first pend=%h drop=%h exp=0008/0000", pend_o, drop_o); else passed++;
    step();
    set_i = '0;
    total++; if (drop_o !== 16'h0008 || pend_o !== 16'h0008) $display("FAIL drop_pulse drop=%h pend=%h exp=0008/0008", drop_o, pend_o); else passed++;
    step();
    total++; if (drop_o !== 16'h0000) $display("FAIL drop_clear got=%h exp=0000", drop_o); else passed++;
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_idx !== 4'd3) $display("FAIL drop_issue valid=%b idx=%0d exp=1/3", out_valid, out_idx); else passed++;
    // Re-setting the bit being issued re-pends it without a drop.
    set_i = 16'h0008; out_ready = 1'b0;
    step();
    set_i = '0;
    total++; if (pend_o !== 16'h0008 || drop_o !== 16'h0000) $display("FAIL repend pend=%h drop=%h exp=0008/0000", pend_o, drop_o); else passed++;
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_idx !== 4'd3 || pend_o !== 16'h0000) $display("FAIL repend_issue valid=%b idx=%0d pend=%h exp=1/3/0000", out_valid, out_idx, pend_o); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL drop_single valid=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_mask();
    occupy_slot();
    set_i = 16'h0044;
    step();
    set_i = '0;
    mask_i = ~16'h0004;
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_idx !== 4'd6 || pend_o !== 16'h0004) $display("FAIL mask_first valid=%b idx=%0d pend=%h exp=1/6/0004", out_valid, out_idx, pend_o); else passed++;
    step();
    total++; if (out_valid !== 1'b0 || pend_o !== 16'h0004) $display("FAIL mask_parked valid=%b pend=%h exp=0/0004", out_valid, pend_o); else passed++;
    // A masked set must neither record nor drop.
    set_i = 16'h0004;
    step();
    set_i = '0;
    total++; if (drop_o !== 16'h0000 || out_valid !== 1'b0) $display("FAIL mask_ignore drop=%h valid=%b exp=0000/0", drop_o, out_valid); else passed++;
    mask_i = '1;
    step();
    total++; if (out_valid !== 1'b1 || out_idx !== 4'd2 || pend_o !== 16'h0000) $display("FAIL mask_reen valid=%b idx=%0d pend=%h exp=1/2/0000", out_valid, out_idx, pend_o); else passed++;
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; set_i = 16'h0001;
    step();
    set_i = 16'h00F0;
    step();
    set_i = '0;
    total++; if (out_valid !== 1'b1 || pend_o !== 16'h00F0) $display("FAIL flush_setup valid=%b pend=%h exp=1/00f0", out_valid, pend_o); else passed++;
    flush_i = 1'b1; set_i = 16'h0002; out_ready = 1'b1;
    step();
    flush_i = 1'b0; set_i = '0;
    total++; if (out_valid !== 1'b0 || pend_o !== 16'h0000 || any_o !== 1'b0) $display("FAIL flush valid=%b pend=%h any=%b exp=0/0000/0", out_valid, pend_o, any_o); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL flush_stay valid=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; set_i = 16'h0011;
    step();
    set_i = '0;
    step();
    total++; if (out_valid !== 1'b1 || pend_o !== 16'h0010) $display("FAIL ares_setup valid=%b pend=%h exp=1/0010", out_valid, pend_o); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || pend_o !== 16'h0000 || out_idx !== 4'd0) $display("FAIL ares valid=%b pend=%h idx=%0d exp=0/0000/0", out_valid, pend_o, out_idx); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++; if (out_valid !== 1'b0 || pend_o !== 16'h0000) $display("FAIL ares_after valid=%b pend=%h exp=0/0000", out_valid, pend_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_drop();
    test_mask();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
